bso_count_led_out: RTL and testbench

//  Parametrised ball/strike/out counter with thermometer LED drive for the scoreboard.

---
 rtl/bso_count_led_out_if.sv | 29 ++
 rtl/bso_count_led_out.sv | 140 ++++++++++++++
 tb/tb_bso_count_led_out.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bso_count_led_out_if.sv
// Umpire-button pulses in, scoreboard LED drive and event pulses out.
// The master side is the pulse source/panel; the slave side is the counter.
interface bso_count_led_out_if #(
    parameter int MAX_BALLS   = 4,
    parameter int MAX_STRIKES = 3,
    parameter int MAX_OUTS    = 3
);
    logic                   ball_pulse;
    logic                   strike_pulse;
    logic                   foul_pulse;
    logic                   out_pulse;
    logic                   batter_end_pulse;
    logic [MAX_BALLS-2:0]   ball_led;
    logic [MAX_STRIKES-2:0] strike_led;
    logic [MAX_OUTS-1:0]    out_led;
    logic                   walk_pulse;
    logic                   strikeout_pulse;
    logic                   change_pulse;

    modport master (
        output ball_pulse, strike_pulse, foul_pulse, out_pulse, batter_end_pulse,
        input  ball_led, strike_led, out_led, walk_pulse, strikeout_pulse, change_pulse
    );

    modport slave (
        input  ball_pulse, strike_pulse, foul_pulse, out_pulse, batter_end_pulse,
        output ball_led, strike_led, out_led, walk_pulse, strikeout_pulse, change_pulse
    );
endinterface

// File: rtl/bso_count_led_out.sv
// Ball/strike/out counter with thermometer LED decode; resolves walks, strikeouts and fouls
// and announces the end of a half-inning with a one-cycle change_pulse.
module bso_count_led_out #(
    parameter int MAX_BALLS      = 4,
    parameter int MAX_STRIKES    = 3,
    parameter int MAX_OUTS       = 3,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bso_count_led_out_if.slave   bus
);
    localparam int BW = $clog2(MAX_BALLS + 1);
    localparam int SW = $clog2(MAX_STRIKES + 1);
    localparam int OW = $clog2(MAX_OUTS + 1);

    typedef enum logic [1:0] {PLAY, CHANGE, CLEAR} state_t;

    state_t        state_reg;
    logic [BW-1:0] balls_reg;
    logic [SW-1:0] strikes_reg;
    logic [OW-1:0] outs_reg;
    logic          walk_pulse_reg;
    logic          strikeout_pulse_reg;
    logic          change_pulse_reg;

    logic clear_bs;
    logic inc_ball;
    logic inc_strike;
    logic add_out;
    logic walk_next;
    logic strikeout_next;

    // One event per edge, highest priority first; lower ones are simply dropped.
    always_comb begin
        clear_bs       = 1'b0;
        inc_ball       = 1'b0;
        inc_strike     = 1'b0;
        add_out        = 1'b0;
        walk_next      = 1'b0;
        strikeout_next = 1'b0;
        if (state_reg == PLAY) begin
            if (bus.batter_end_pulse) begin
                clear_bs = 1'b1;
            end else if (bus.out_pulse) begin
                clear_bs = 1'b1;
                add_out  = 1'b1;
            end else if (bus.strike_pulse) begin
                if (strikes_reg == SW'(MAX_STRIKES - 1)) begin
                    strikeout_next = 1'b1;
                    clear_bs       = 1'b1;
                    add_out        = 1'b1;
                end else begin
                    inc_strike = 1'b1;
                end
            end else if (bus.foul_pulse) begin
                // A foul never produces the final strike.
                inc_strike = (strikes_reg < SW'(MAX_STRIKES - 1));
            end else if (bus.ball_pulse) begin
                if (balls_reg == BW'(MAX_BALLS - 1)) begin
                    walk_next = 1'b1;
                    clear_bs  = 1'b1;
                end else begin
                    inc_ball = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg           <= PLAY;
            balls_reg           <= '0;
            strikes_reg         <= '0;
            outs_reg            <= '0;
            walk_pulse_reg      <= 1'b0;
            strikeout_pulse_reg <= 1'b0;
            change_pulse_reg    <= 1'b0;
        end else begin
            walk_pulse_reg      <= walk_next;
            strikeout_pulse_reg <= strikeout_next;
            change_pulse_reg    <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (clear_bs) begin
                        balls_reg   <= '0;
                        strikes_reg <= '0;
                    end else if (inc_ball) begin
                        balls_reg <= balls_reg + 1'b1;
                    end else if (inc_strike) begin
                        strikes_reg <= strikes_reg + 1'b1;
                    end
                    if (add_out) begin
                        outs_reg <= outs_reg + 1'b1;
                        if (outs_reg == OW'(MAX_OUTS - 1)) begin
                            state_reg        <= CHANGE;
                            change_pulse_reg <= 1'b1;
                        end
                    end
                end
                CHANGE: begin
                    state_reg <= CLEAR;
                end
                CLEAR: begin
                    state_reg   <= PLAY;
                    balls_reg   <= '0;
                    strikes_reg <= '0;
                    outs_reg    <= '0;
                end
                default: begin
                    state_reg <= PLAY;
                end
            endcase
        end
    end

    logic [MAX_BALLS-2:0]   ball_lit;
    logic [MAX_STRIKES-2:0] strike_lit;
    logic [MAX_OUTS-1:0]    out_lit;

    // Between half-innings the out row stays full and the count rows go dark.
    generate
        for (genvar gi = 0; gi < MAX_BALLS - 1; gi++) begin : g_ball
            assign ball_lit[gi] = (state_reg == PLAY) && (balls_reg > BW'(gi));
        end
        for (genvar gi = 0; gi < MAX_STRIKES - 1; gi++) begin : g_strike
            assign strike_lit[gi] = (state_reg == PLAY) && (strikes_reg > SW'(gi));
        end
        for (genvar gi = 0; gi < MAX_OUTS; gi++) begin : g_out
            assign out_lit[gi] = (state_reg != PLAY) || (outs_reg > OW'(gi));
        end
    endgenerate

    assign bus.ball_led        = ball_lit   ^ {(MAX_BALLS - 1){LED_ACTIVE_LOW}};
    assign bus.strike_led      = strike_lit ^ {(MAX_STRIKES - 1){LED_ACTIVE_LOW}};
    assign bus.out_led         = out_lit    ^ {MAX_OUTS{LED_ACTIVE_LOW}};
    assign bus.walk_pulse      = walk_pulse_reg;
    assign bus.strikeout_pulse = strikeout_pulse_reg;
    assign bus.change_pulse    = change_pulse_reg;
endmodule

// File: tb/tb_bso_count_led_out.sv
// Directed bench: one table of single-cycle vectors plus hand-written half-inning sequences,
// run on an active-low 3-out instance and an active-high 4-out instance.
module tb_bso_count_led_out;
    logic clk;
    logic rst_n;
    int   sel;
    int   mo;
    bit   al;
    int   total_cnt;
    int   pass_cnt;

    logic p_ball, p_strike, p_foul, p_out, p_be;

    bso_count_led_out_if #(.MAX_BALLS(4), .MAX_STRIKES(3), .MAX_OUTS(3)) bus_a ();
    bso_count_led_out_if #(.MAX_BALLS(4), .MAX_STRIKES(3), .MAX_OUTS(4)) bus_b ();

    bso_count_led_out #(.MAX_BALLS(4), .MAX_STRIKES(3), .MAX_OUTS(3), .LED_ACTIVE_LOW(1'b1))
        dut_a (.clk(clk), .reset_n(rst_n), .bus(bus_a.slave));
    bso_count_led_out #(.MAX_BALLS(4), .MAX_STRIKES(3), .MAX_OUTS(4), .LED_ACTIVE_LOW(1'b0))
        dut_b (.clk(clk), .reset_n(rst_n), .bus(bus_b.slave));

    assign bus_a.ball_pulse       = (sel == 0) && p_ball;
    assign bus_a.strike_pulse     = (sel == 0) && p_strike;
    assign bus_a.foul_pulse       = (sel == 0) && p_foul;
    assign bus_a.out_pulse        = (sel == 0) && p_out;
    assign bus_a.batter_end_pulse = (sel == 0) && p_be;
    assign bus_b.ball_pulse       = (sel == 1) && p_ball;
    assign bus_b.strike_pulse     = (sel == 1) && p_strike;
    assign bus_b.foul_pulse       = (sel == 1) && p_foul;
    assign bus_b.out_pulse        = (sel == 1) && p_out;
    assign bus_b.batter_end_pulse = (sel == 1) && p_be;

    logic [2:0] cur_ball;
    logic [1:0] cur_strike;
    logic [3:0] cur_out;
    logic       cur_walk, cur_so, cur_chg;

    assign cur_ball   = (sel == 1) ? bus_b.ball_led : bus_a.ball_led;
    assign cur_strike = (sel == 1) ? bus_b.strike_led : bus_a.strike_led;
    assign cur_out    = (sel == 1) ? bus_b.out_led : {1'b0, bus_a.out_led};
    assign cur_walk   = (sel == 1) ? bus_b.walk_pulse : bus_a.walk_pulse;
    assign cur_so     = (sel == 1) ? bus_b.strikeout_pulse : bus_a.strikeout_pulse;
    assign cur_chg    = (sel == 1) ? bus_b.change_pulse : bus_a.change_pulse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  b, s, f, o, e;
        int    eb, es, eo;
        logic  ew, eso, ec;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [3:0] therm(input int n, input int w, input bit act_low);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (n > i) ? ~act_low : act_low;
        return r;
    endfunction

    task automatic step(input logic b, input logic s, input logic f, input logic o, input logic e);
        p_ball = b; p_strike = s; p_foul = f; p_out = o; p_be = e;
        @(posedge clk);
        #1;
        p_ball = 0; p_strike = 0; p_foul = 0; p_out = 0; p_be = 0;
    endtask

    task automatic check(input string name, input int eb, input int es, input int eo,
                         input logic ew, input logic eso, input logic ec);
        logic [14:0] exp_v, act_v;
        logic [3:0]  tb_, ts_, to_;
        tb_ = therm(eb, 3, al);
        ts_ = therm(es, 2, al);
        to_ = therm(eo, mo, al);
        exp_v = {ew, eso, ec, tb_, ts_, to_};
        act_v = {cur_walk, cur_so, cur_chg, 1'b0, cur_ball, 2'b00, cur_strike, cur_out};
        total_cnt++;
        if (act_v === exp_v) begin
            pass_cnt++;
            $display("cfg%0d %-18s ok   walk/so/chg/ball/strike/out = %b", sel, name, act_v);
        end else begin
            $display("FAIL cfg%0d %s: got walk=%b so=%b chg=%b ball=%b strike=%b out=%b, want walk=%b so=%b chg=%b ball=%b strike=%b out=%b",
                     sel, name, act_v[14], act_v[13], act_v[12], act_v[10:8], act_v[5:4], act_v[3:0],
                     exp_v[14], exp_v[13], exp_v[12], exp_v[10:8], exp_v[5:4], exp_v[3:0]);
        end
    endtask

    task automatic outs_to(input int from, input int target);
        for (int k = from; k < target; k++) begin
            step(0, 0, 0, 1, 0);
            check("out_step", 0, 0, k + 1, 0, 0, 0);
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        sel = 0; mo = 3; al = 1'b1;
        rst_n = 1'b0;
        p_ball = 0; p_strike = 0; p_foul = 0; p_out = 0; p_be = 0;

        //          name          b s f o e  eb es eo  w  k  c
        tbl.push_back('{"ball1",       1,0,0,0,0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{"ball2",       1,0,0,0,0, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{"ball3",       1,0,0,0,0, 3, 0, 0, 0, 0, 0});
        tbl.push_back('{"ball4_walk",  1,0,0,0,0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{"walk_ends",   0,0,0,0,0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{"strike1",     0,1,0,0,0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{"strike2",     0,1,0,0,0, 0, 2, 0, 0, 0, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{"foul_at_2",   0,0,1,0,0, 0, 2, 0, 0, 0, 0});
        tbl.push_back('{"strikeout",   0,1,0,0,0, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{"k_ends",      0,0,0,0,0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{"ball1b",      1,0,0,0,0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{"strike1b",    0,1,0,0,0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{"strike_ball", 1,1,0,0,0, 1, 2, 1, 0, 0, 0});
        tbl.push_back('{"foul_ball",   1,0,1,0,0, 1, 2, 1, 0, 0, 0});
        tbl.push_back('{"out_be",      0,0,0,1,1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{"ball1c",      1,0,0,0,0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{"out2",        0,0,0,1,0, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{"b_s_f",       1,1,1,0,0, 0, 1, 2, 0, 0, 0});
        tbl.push_back('{"batter_end",  0,0,0,0,1, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{"foul_0",      0,0,1,0,0, 0, 1, 2, 0, 0, 0});
        tbl.push_back('{"foul_1",      0,0,1,0,0, 0, 2, 2, 0, 0, 0});
        tbl.push_back('{"batter_end2", 0,0,0,0,1, 0, 0, 2, 0, 0, 0});

        for (int c = 0; c < 2; c++) begin
            sel = c;
            mo  = (c == 1) ? 4 : 3;
            al  = (c == 1) ? 1'b0 : 1'b1;

            // Reset wins over a simultaneous pulse.
            rst_n = 1'b0;
            step(1, 1, 0, 1, 0);
            step(0, 0, 0, 0, 0);
            check("reset", 0, 0, 0, 0, 0, 0);
            rst_n = 1'b1;
            step(0, 0, 0, 0, 0);
            check("idle_after_reset", 0, 0, 0, 0, 0, 0);

            foreach (tbl[i]) begin
                step(tbl[i].b, tbl[i].s, tbl[i].f, tbl[i].o, tbl[i].e);
                check(tbl[i].name, tbl[i].eb, tbl[i].es, tbl[i].eo, tbl[i].ew, tbl[i].eso, tbl[i].ec);
            end

            // Half-inning ends on a batted out; pulses in CHANGE and CLEAR are ignored.
            outs_to(2, mo - 1);
            step(0, 0, 0, 1, 0);
            check("change", 0, 0, mo, 0, 0, 1);
            step(1, 0, 0, 0, 0);
            check("clear_ign_ball", 0, 0, mo, 0, 0, 0);
            step(1, 1, 0, 1, 0);
            check("play_after_clr", 0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            check("play_idle", 0, 0, 0, 0, 0, 0);

            // Final out by strikeout: both pulses in the same cycle.
            outs_to(0, mo - 1);
            step(0, 1, 0, 0, 0);
            check("k_setup1", 0, 1, mo - 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            check("k_setup2", 0, 2, mo - 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            check("k_change", 0, 0, mo, 0, 1, 1);
            step(0, 0, 0, 0, 0);
            check("k_clear", 0, 0, mo, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            check("k_play", 0, 0, 0, 0, 0, 0);

            // Reset while in CHANGE: back to PLAY with no further change_pulse.
            outs_to(0, mo - 1);
            step(0, 0, 0, 1, 0);
            check("change2", 0, 0, mo, 0, 0, 1);
            rst_n = 1'b0;
            step(1, 0, 0, 0, 0);
            check("reset_in_change", 0, 0, 0, 0, 0, 0);
            rst_n = 1'b1;
            step(0, 0, 0, 0, 0);
            check("post_reset_idle", 0, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            check("post_reset_ball", 1, 0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
